// File: rtl/cyt_mm2s_pkt_arbiter_pkg.sv
// Shared types for the MM2S packet arbiter: source tag encoding, FSM states
// and the round-robin tie-break helper.
package cyt_mm2s_pkt_arbiter_pkg;

    localparam logic TID_HOST = 1'b1;
    localparam logic TID_CARD = 1'b0;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_HOST,
        ARB_BUSY_CARD
    } arb_state_t;

    // Host wins when it is the only eligible port, or on a tie when card went last.
    function automatic logic rr_pick_host(
        input logic host_elig,
        input logic card_elig,
        input logic last_grant
    );
        return host_elig & (~card_elig | (last_grant == TID_CARD));
    endfunction

endpackage

// File: rtl/cyt_mm2s_pkt_arbiter_skid.sv
// Two-entry AXI-Stream output stage: a main register plus one skid register,
// giving full throughput with a registered input ready.
module axis_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             main_valid;
    logic             skid_valid;
    logic             in_fire;

    assign in_fire   = in_valid & ~skid_valid;
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (main_valid & ~out_ready) begin
            // Output stalled: main holds, at most one extra beat parks in the skid.
            if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end else if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end else begin
            main_valid <= in_fire;
            if (in_fire) begin
                main_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/cyt_mm2s_pkt_arbiter.sv
// Packet-granular round-robin 2:1 arbiter merging the host and card MM2S
// streams of one DMA channel, tagging every beat with its source in m_tid.
module cyt_mm2s_pkt_arbiter
    import cyt_mm2s_pkt_arbiter_pkg::*;
#(
    parameter int unsigned DATA_BITS = 512,
    parameter int unsigned CNT_BITS  = 32
) (
    input  logic                   aclk,
    input  logic                   areset,

    input  logic [DATA_BITS-1:0]   s_host_tdata,
    input  logic [DATA_BITS/8-1:0] s_host_tkeep,
    input  logic                   s_host_tlast,
    input  logic                   s_host_tvalid,
    output logic                   s_host_tready,

    input  logic [DATA_BITS-1:0]   s_card_tdata,
    input  logic [DATA_BITS/8-1:0] s_card_tkeep,
    input  logic                   s_card_tlast,
    input  logic                   s_card_tvalid,
    output logic                   s_card_tready,

    input  logic                   host_suppress,
    input  logic                   card_suppress,

    output logic [DATA_BITS-1:0]   m_tdata,
    output logic [DATA_BITS/8-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    output logic                   m_tid,
    input  logic                   m_tready,

    output logic [CNT_BITS-1:0]    pkt_cnt_host,
    output logic [CNT_BITS-1:0]    pkt_cnt_card,
    output logic                   busy
);

    localparam int unsigned KEEP_BITS    = DATA_BITS / 8;
    localparam int unsigned PAYLOAD_BITS = DATA_BITS + KEEP_BITS + 2;

    arb_state_t              state;
    arb_state_t              state_next;
    logic                    last_grant;
    logic                    in_rdy;
    logic                    host_elig;
    logic                    card_elig;
    logic                    sel_host;
    logic                    sel_card;
    logic                    host_fire;
    logic                    card_fire;
    logic                    in_valid;
    logic [PAYLOAD_BITS-1:0] in_payload;
    logic [PAYLOAD_BITS-1:0] out_payload;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: begin
                if (host_fire & ~s_host_tlast) begin
                    state_next = ARB_BUSY_HOST;
                end else if (card_fire & ~s_card_tlast) begin
                    state_next = ARB_BUSY_CARD;
                end
            end
            ARB_BUSY_HOST: begin
                if (host_fire & s_host_tlast) begin
                    state_next = ARB_IDLE;
                end
            end
            ARB_BUSY_CARD: begin
                if (card_fire & s_card_tlast) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Suppress only gates new grants, so it is ignored once a packet is in flight.
    always_comb begin
        host_elig = s_host_tvalid & ~host_suppress & in_rdy;
        card_elig = s_card_tvalid & ~card_suppress & in_rdy;
        sel_host  = 1'b0;
        sel_card  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                sel_host = rr_pick_host(host_elig, card_elig, last_grant);
                sel_card = card_elig & ~sel_host;
            end
            ARB_BUSY_HOST: sel_host = 1'b1;
            ARB_BUSY_CARD: sel_card = 1'b1;
            default: begin
                sel_host = 1'b0;
                sel_card = 1'b0;
            end
        endcase

        s_host_tready = sel_host & in_rdy & ~areset;
        s_card_tready = sel_card & in_rdy & ~areset;
        host_fire     = s_host_tready & s_host_tvalid;
        card_fire     = s_card_tready & s_card_tvalid;
        in_valid      = host_fire | card_fire;

        if (sel_host) begin
            in_payload = {s_host_tdata, s_host_tkeep, s_host_tlast, TID_HOST};
        end else begin
            in_payload = {s_card_tdata, s_card_tkeep, s_card_tlast, TID_CARD};
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_grant   <= TID_CARD;
            pkt_cnt_host <= '0;
            pkt_cnt_card <= '0;
        end else if (host_fire & s_host_tlast) begin
            last_grant   <= TID_HOST;
            pkt_cnt_host <= pkt_cnt_host + 1'b1;
        end else if (card_fire & s_card_tlast) begin
            last_grant   <= TID_CARD;
            pkt_cnt_card <= pkt_cnt_card + 1'b1;
        end
    end

    assign busy = (state != ARB_IDLE);

    axis_skid_buffer #(
        .WIDTH(PAYLOAD_BITS)
    ) u_out_stage (
        .clk      (aclk),
        .rst      (areset),
        .in_valid (in_valid),
        .in_ready (in_rdy),
        .in_data  (in_payload),
        .out_valid(m_tvalid),
        .out_ready(m_tready),
        .out_data (out_payload)
    );

    assign {m_tdata, m_tkeep, m_tlast, m_tid} = out_payload;

endmodule

// File: tb/tb_cyt_mm2s_pkt_arbiter.sv
// Bench for cyt_mm2s_pkt_arbiter: IDLE arbitration vector table, then packet
// scenarios checked against per-source packet queues and handshake rules.
module tb_cyt_mm2s_pkt_arbiter;

    localparam int unsigned DB = 64;
    localparam int unsigned KB = DB / 8;
    localparam int unsigned CB = 4;
    localparam int          CNT_MOD = 1 << CB;

    logic          clk;
    logic          areset;
    logic [DB-1:0] s_host_tdata;
    logic [KB-1:0] s_host_tkeep;
    logic          s_host_tlast;
    logic          s_host_tvalid;
    logic          s_host_tready;
    logic [DB-1:0] s_card_tdata;
    logic [KB-1:0] s_card_tkeep;
    logic          s_card_tlast;
    logic          s_card_tvalid;
    logic          s_card_tready;
    logic          host_suppress;
    logic          card_suppress;
    logic [DB-1:0] m_tdata;
    logic [KB-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tid;
    logic          m_tready;
    logic [CB-1:0] pkt_cnt_host;
    logic [CB-1:0] pkt_cnt_card;
    logic          busy;

    cyt_mm2s_pkt_arbiter #(
        .DATA_BITS(DB),
        .CNT_BITS (CB)
    ) dut (
        .aclk         (clk),
        .areset       (areset),
        .s_host_tdata (s_host_tdata),
        .s_host_tkeep (s_host_tkeep),
        .s_host_tlast (s_host_tlast),
        .s_host_tvalid(s_host_tvalid),
        .s_host_tready(s_host_tready),
        .s_card_tdata (s_card_tdata),
        .s_card_tkeep (s_card_tkeep),
        .s_card_tlast (s_card_tlast),
        .s_card_tvalid(s_card_tvalid),
        .s_card_tready(s_card_tready),
        .host_suppress(host_suppress),
        .card_suppress(card_suppress),
        .m_tdata      (m_tdata),
        .m_tkeep      (m_tkeep),
        .m_tlast      (m_tlast),
        .m_tvalid     (m_tvalid),
        .m_tid        (m_tid),
        .m_tready     (m_tready),
        .pkt_cnt_host (pkt_cnt_host),
        .pkt_cnt_card (pkt_cnt_card),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DB-1:0] data;
        logic [KB-1:0] keep;
        logic          last;
    } beat_t;

    // {host_valid, card_valid, host_sup, card_sup, exp_host_rdy, exp_card_rdy, exp_m_valid, exp_m_tid}
    typedef struct packed {
        logic hv, cv, hs, cs, ehr, ecr, evalid, etid;
    } vec_t;

    beat_t  src_h[$], src_c[$], exp_h[$], exp_c[$];
    logic   order[$];
    int     acc_cyc[$];

    int     tests, fails, cyc;
    int     occ, max_occ, viol_both, card_rdy_seen, acc_h, acc_c;
    int     exp_cnt_h, exp_cnt_c, first_out, last_out, ready_pct;
    bit     rnd_valid, rnd_ready, rnd_sup, lat_check, hold_h, hold_c, in_pkt;
    bit     prev_stall, sup_h_req, sup_c_req;
    logic   cur_tid, busy_seen, prev_last, prev_tid;
    logic [DB-1:0] prev_data;
    logic [KB-1:0] prev_keep;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic zero_inputs();
        s_host_tvalid = 1'b0; s_host_tdata = '0; s_host_tkeep = '0; s_host_tlast = 1'b0;
        s_card_tvalid = 1'b0; s_card_tdata = '0; s_card_tkeep = '0; s_card_tlast = 1'b0;
        host_suppress = 1'b0; card_suppress = 1'b0; m_tready = 1'b1;
    endtask

    task automatic flush();
        src_h.delete(); src_c.delete(); exp_h.delete(); exp_c.delete();
        order.delete(); acc_cyc.delete();
        occ = 0; max_occ = 0; viol_both = 0; card_rdy_seen = 0; acc_h = 0; acc_c = 0;
        exp_cnt_h = 0; exp_cnt_c = 0; first_out = -1; last_out = -1;
        hold_h = 0; hold_c = 0; in_pkt = 0; prev_stall = 0; busy_seen = 1'b0;
        sup_h_req = 0; sup_c_req = 0; rnd_valid = 0; rnd_ready = 0; rnd_sup = 0; lat_check = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        areset = 1'b1;
        zero_inputs();
        @(negedge clk);
        areset = 1'b0;
        flush();
    endtask

    task automatic gen_pkt(input bit host, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KB'($urandom);
            b.last = (i == len - 1);
            if (host) begin
                src_h.push_back(b); exp_h.push_back(b);
            end else begin
                src_c.push_back(b); exp_c.push_back(b);
            end
        end
        if (host) exp_cnt_h++; else exp_cnt_c++;
    endtask

    task automatic drive();
        if (!hold_h) s_host_tvalid = (src_h.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        if (!hold_c) s_card_tvalid = (src_c.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        if (src_h.size() > 0) begin
            s_host_tdata = src_h[0].data; s_host_tkeep = src_h[0].keep; s_host_tlast = src_h[0].last;
        end
        if (src_c.size() > 0) begin
            s_card_tdata = src_c[0].data; s_card_tkeep = src_c[0].keep; s_card_tlast = src_c[0].last;
        end
        host_suppress = sup_h_req || (rnd_sup && $urandom_range(0, 7) == 0);
        card_suppress = sup_c_req || (rnd_sup && $urandom_range(0, 7) == 0);
        m_tready = rnd_ready ? ($urandom_range(0, 99) < ready_pct) : 1'b1;
    endtask

    task automatic check_out();
        beat_t e;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        if (in_pkt) check("no_interleave", 64'(m_tid), 64'(cur_tid));
        if ((m_tid && exp_h.size() == 0) || (!m_tid && exp_c.size() == 0)) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: got beat with tid %0d, required no beat", m_tid);
        end else begin
            if (m_tid) e = exp_h.pop_front(); else e = exp_c.pop_front();
            check("out_data", 64'(m_tdata), 64'(e.data));
            check("out_keep", 64'(m_tkeep), 64'(e.keep));
            check("out_last", 64'(m_tlast), 64'(e.last));
        end
        if (lat_check && acc_cyc.size() > 0) check("latency", 64'(cyc - acc_cyc.pop_front()), 64'd1);
        in_pkt  = !m_tlast;
        cur_tid = m_tid;
        if (m_tlast) order.push_back(m_tid);
    endtask

    task automatic sample();
        cyc++;
        busy_seen = busy_seen | busy;
        if (prev_stall) begin
            check("stall_data", 64'(m_tdata), 64'(prev_data));
            check("stall_ctrl", 64'({m_tvalid, m_tkeep, m_tlast, m_tid}),
                  64'({1'b1, prev_keep, prev_last, prev_tid}));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast; prev_tid = m_tid;
        if (s_host_tready && s_card_tready) viol_both++;
        if (s_card_tready) card_rdy_seen++;
        if (s_host_tvalid && s_host_tready) begin
            void'(src_h.pop_front()); acc_h++; occ++;
            if (lat_check) acc_cyc.push_back(cyc);
        end
        if (s_card_tvalid && s_card_tready) begin
            void'(src_c.pop_front()); acc_c++; occ++;
        end
        hold_h = s_host_tvalid && !s_host_tready;
        hold_c = s_card_tvalid && !s_card_tready;
        if (m_tvalid && m_tready) begin
            occ--;
            check_out();
        end
        if (occ > max_occ) max_occ = occ;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #4;
        sample();
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while ((exp_h.size() > 0 || exp_c.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", 64'(exp_h.size() + exp_c.size()), 64'd0);
    endtask

    task automatic end_phase();
        check("max_occupancy_le2", 64'(max_occ <= 2), 64'd1);
        check("both_tready", 64'(viol_both), 64'd0);
        check("pkt_cnt_host", 64'(pkt_cnt_host), 64'(exp_cnt_h % CNT_MOD));
        check("pkt_cnt_card", 64'(pkt_cnt_card), 64'(exp_cnt_c % CNT_MOD));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int   n, c0;
        tests = 0; fails = 0; cyc = 0; ready_pct = 100;
        flush();
        areset = 1'b1;
        zero_inputs();
        s_host_tvalid = 1'b1;
        s_card_tvalid = 1'b1;

        vecs[0]  = 8'b0000_0000;
        vecs[1]  = 8'b1100_1011;  // tie, card went last -> host
        vecs[2]  = 8'b1100_0110;
        vecs[3]  = 8'b1000_1011;
        vecs[4]  = 8'b1000_1011;
        vecs[5]  = 8'b1100_0110;
        vecs[6]  = 8'b1110_0110;
        vecs[7]  = 8'b1101_1011;
        vecs[8]  = 8'b1111_0000;
        vecs[9]  = 8'b0100_0110;
        vecs[10] = 8'b1100_1011;
        vecs[11] = 8'b0000_0000;

        // Reset values
        repeat (3) @(negedge clk);
        #4;
        check("rst_host_tready", 64'(s_host_tready), 64'd0);
        check("rst_card_tready", 64'(s_card_tready), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        zero_inputs();
        #4;
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tid", 64'(m_tid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt_host", 64'(pkt_cnt_host), 64'd0);
        check("rst_cnt_card", 64'(pkt_cnt_card), 64'd0);

        // IDLE arbitration table, single-beat packets
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s_host_tvalid = vecs[i].hv; s_card_tvalid = vecs[i].cv;
            host_suppress = vecs[i].hs; card_suppress = vecs[i].cs;
            s_host_tdata = 64'hA000 + 64'(i); s_card_tdata = 64'hC000 + 64'(i);
            s_host_tkeep = '1; s_card_tkeep = '1;
            s_host_tlast = 1'b1; s_card_tlast = 1'b1; m_tready = 1'b1;
            #4;
            check("tbl_host_tready", 64'(s_host_tready), 64'(vecs[i].ehr));
            check("tbl_card_tready", 64'(s_card_tready), 64'(vecs[i].ecr));
            @(posedge clk);
            #1;
            check("tbl_m_tvalid", 64'(m_tvalid), 64'(vecs[i].evalid));
            if (m_tvalid && vecs[i].evalid) begin
                check("tbl_m_tid", 64'(m_tid), 64'(vecs[i].etid));
                check("tbl_m_tdata", 64'(m_tdata),
                      vecs[i].etid ? 64'hA000 + 64'(i) : 64'hC000 + 64'(i));
            end
        end
        @(negedge clk);
        zero_inputs();
        #4;
        check("tbl_cnt_host", 64'(pkt_cnt_host), 64'd5);
        check("tbl_cnt_card", 64'(pkt_cnt_card), 64'd4);

        // Single source: host 4-beat packet, one-cycle latency
        do_reset();
        lat_check = 1;
        gen_pkt(1, 4);
        run_until_drained(50);
        end_phase();
        check("single_card_tready_seen", 64'(card_rdy_seen), 64'd0);
        check("single_busy_seen", 64'(busy_seen), 64'd1);
        lat_check = 0;

        // Fairness: both ports loaded with 3-beat packets
        do_reset();
        for (int p = 0; p < 3; p++) begin
            gen_pkt(1, 3);
            gen_pkt(0, 3);
        end
        run_until_drained(100);
        end_phase();
        check("fair_pkt_count", 64'(order.size()), 64'd6);
        for (int k = 0; k < order.size(); k++) check("fair_order", 64'(order[k]), 64'(k % 2 == 0));
        check("fair_no_gaps", 64'(last_out - first_out + 1), 64'd18);

        // Backpressure with random valid gaps, ready and suppress
        do_reset();
        rnd_valid = 1; rnd_ready = 1; rnd_sup = 1; ready_pct = 55;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < 6; p++) begin
                gen_pkt(1, (r == 0) ? 8 : int'($urandom_range(1, 8)));
                gen_pkt(0, (r == 0) ? 8 : int'($urandom_range(1, 8)));
            end
        end
        run_until_drained(4000);
        end_phase();
        rnd_valid = 0; rnd_ready = 0; rnd_sup = 0;

        // Suppress asserted mid card packet
        do_reset();
        gen_pkt(0, 5);
        gen_pkt(0, 3);
        n = 0;
        while (acc_c < 2 && n < 50) begin cycle(); n++; end
        check("sup_wait_start", 64'(acc_c >= 2), 64'd1);
        sup_c_req = 1;
        gen_pkt(1, 3);
        gen_pkt(1, 3);
        n = 0;
        while (!(exp_c.size() == 3 && exp_h.size() == 0) && n < 100) begin cycle(); n++; end
        check("sup_wait_host", 64'(exp_c.size() == 3 && exp_h.size() == 0), 64'd1);
        check("sup_pkt_count", 64'(order.size()), 64'd3);
        if (order.size() == 3) begin
            check("sup_order0", 64'(order[0]), 64'd0);
            check("sup_order1", 64'(order[1]), 64'd1);
            check("sup_order2", 64'(order[2]), 64'd1);
        end
        sup_c_req = 0;
        c0 = cyc;
        run_until_drained(50);
        check("sup_release_cycles", 64'(cyc - c0), 64'd4);
        end_phase();

        // Reset during beat 2 of a 5-beat host packet
        do_reset();
        gen_pkt(1, 5);
        n = 0;
        while (acc_h < 2 && n < 50) begin cycle(); n++; end
        check("rst_mid_wait", 64'(acc_h >= 2), 64'd1);
        @(negedge clk);
        areset = 1'b1;
        drive();
        #4;
        check("rst_mid_host_tready", 64'(s_host_tready), 64'd0);
        check("rst_mid_card_tready", 64'(s_card_tready), 64'd0);
        @(negedge clk);
        areset = 1'b0;
        flush();
        zero_inputs();
        #4;
        check("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_mid_cnt_host", 64'(pkt_cnt_host), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        gen_pkt(1, 3);
        run_until_drained(50);
        end_phase();

        // Single-beat card packets across the counter wrap
        busy_seen = 1'b0;
        for (int p = 0; p < CNT_MOD - 1; p++) gen_pkt(0, 1);
        run_until_drained(100);
        check("wrap_cnt_card_max", 64'(pkt_cnt_card), 64'(CNT_MOD - 1));
        gen_pkt(0, 1);
        run_until_drained(20);
        check("wrap_cnt_card_zero", 64'(pkt_cnt_card), 64'd0);
        check("wrap_busy_seen", 64'(busy_seen), 64'd0);
        end_phase();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
